// File: rtl/sha3_pkg.sv
// Shared definitions for the permutation round controller: default round count and FSM states.
package sha3_pkg;

    localparam int unsigned NROUND_DEF = 24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } round_state_e;

endpackage

// File: rtl/round_ctrl_if.sv
// Request/round/result handshake between the permutation parent (master) and round_ctrl (slave).
interface round_ctrl_if #(
    parameter int unsigned NROUND = 24
);

    logic              in_valid;
    logic              in_ready;
    logic              load;
    logic              round_en;
    logic [NROUND-1:0] round_onehot;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  load,
        input  round_en,
        input  round_onehot,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output load,
        output round_en,
        output round_onehot,
        output out_valid
    );

endinterface

// File: rtl/round_ctrl.sv
// Round sequencer for an iterated permutation: accept, NROUND one-hot rounds, hold result until taken.
// Define ROUND_CTRL_OVERLAP_EN to let DONE accept the next request in the cycle its result is taken.
module round_ctrl
    import sha3_pkg::*;
#(
    parameter int unsigned NROUND = NROUND_DEF
) (
    input  logic         clk,
    input  logic         reset,
    round_ctrl_if.slave  bus
);

    localparam logic [NROUND-1:0] FIRST_ROUND = NROUND'(1);

    round_state_e      state;
    logic [NROUND-1:0] onehot_q;
    logic              round_en_q;
    logic              out_valid_q;
    logic              idle_q;
    logic              in_ready_w;
    logic              load_w;

    // in_ready stays combinational only for the DONE-state overlap path.
    always_comb begin
        in_ready_w = idle_q;
`ifdef ROUND_CTRL_OVERLAP_EN
        in_ready_w = idle_q | (out_valid_q & bus.out_ready);
`endif
        load_w = reset & bus.in_valid & in_ready_w;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            onehot_q    <= '0;
            round_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_w) begin
                        state      <= RUN;
                        onehot_q   <= FIRST_ROUND;
                        round_en_q <= 1'b1;
                        idle_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (onehot_q[NROUND-1]) begin
                        state       <= DONE;
                        onehot_q    <= '0;
                        round_en_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        onehot_q <= onehot_q << 1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef ROUND_CTRL_OVERLAP_EN
                        if (load_w) begin
                            state      <= RUN;
                            onehot_q   <= FIRST_ROUND;
                            round_en_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            idle_q <= 1'b1;
                        end
`else
                        state  <= IDLE;
                        idle_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    onehot_q    <= '0;
                    round_en_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    idle_q      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_w;
    assign bus.load         = load_w;
    assign bus.round_en     = round_en_q;
    assign bus.round_onehot = onehot_q;
    assign bus.out_valid    = out_valid_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: fixed vectors, corner-case sequences and randomized traffic
// against a cycle-age reference model. Honours ROUND_CTRL_OVERLAP_EN like the design.
module tb_round_ctrl;

    localparam int unsigned NR = 24;
`ifdef ROUND_CTRL_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    round_ctrl_if #(.NROUND(NR)) bus ();

    round_ctrl #(.NROUND(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: age 0 = idle, 1..NR = executing round age, NR+1 = result waiting.
    int age = 0;
    int cyc = 0;

    logic        s_ir, s_load, s_ren, s_ov;
    logic [31:0] s_oh;

    typedef struct {
        bit          iv;
        bit          ordy;
        bit          rst;
        bit          e_ir;
        bit          e_load;
        bit          e_ren;
        bit          e_ov;
        logic [31:0] e_oh;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit iv, input bit ordy, input bit rst,
                              output bit e_ir, output bit e_load, output bit e_ren,
                              output bit e_ov, output logic [31:0] e_oh);
        int nxt;
        e_ir   = (age == 0) || (OVL && age == NR + 1 && ordy);
        e_load = rst && iv && e_ir;
        e_ren  = (age >= 1) && (age <= NR);
        e_oh   = e_ren ? (32'd1 << (age - 1)) : 32'd0;
        e_ov   = (age == NR + 1);
        if (!rst)
            nxt = 0;
        else if (age == 0)
            nxt = e_load ? 1 : 0;
        else if (age <= NR)
            nxt = age + 1;
        else
            nxt = ordy ? (e_load ? 1 : 0) : age;
        age = nxt;
    endtask

    task automatic drive_sample(input bit iv, input bit ordy, input bit rst);
        @(posedge clk);
        cyc++;
        #1;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        reset         = rst;
        #4;
        s_ir   = bus.in_ready;
        s_load = bus.load;
        s_ren  = bus.round_en;
        s_ov   = bus.out_valid;
        s_oh   = 32'(bus.round_onehot);
        chk("onehot0", 32'($onehot0(bus.round_onehot)), 32'd1);
        chk("round_en_vs_onehot", 32'(s_ren), 32'(s_oh != 0));
    endtask

    task automatic cycle(input bit iv, input bit ordy, input bit rst);
        bit e_ir, e_load, e_ren, e_ov;
        logic [31:0] e_oh;
        drive_sample(iv, ordy, rst);
        model_step(iv, ordy, rst, e_ir, e_load, e_ren, e_ov, e_oh);
        chk("in_ready", 32'(s_ir), 32'(e_ir));
        chk("load", 32'(s_load), 32'(e_load));
        chk("round_en", 32'(s_ren), 32'(e_ren));
        chk("out_valid", 32'(s_ov), 32'(e_ov));
        chk("round_onehot", s_oh, e_oh);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ov_cyc, ren_cnt, ov_cnt, ir_cnt, ld_cnt, hs_cnt, first_ld, second_ld;
        bit d_ir, d_load, d_ren, d_ov;
        logic [31:0] d_oh;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;
        repeat (2) @(posedge clk);
        age = 0;

        //           iv ordy rst  ir ld ren ov  oh
        vecs[0] = '{1, 0, 0,  1, 0, 0, 0, 32'h0};
        vecs[1] = '{0, 0, 1,  1, 0, 0, 0, 32'h0};
        vecs[2] = '{1, 0, 1,  1, 1, 0, 0, 32'h0};
        vecs[3] = '{1, 0, 1,  0, 0, 1, 0, 32'h1};
        vecs[4] = '{0, 0, 1,  0, 0, 1, 0, 32'h2};
        vecs[5] = '{1, 0, 0,  0, 0, 1, 0, 32'h4};
        vecs[6] = '{0, 0, 1,  1, 0, 0, 0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            drive_sample(vecs[i].iv, vecs[i].ordy, vecs[i].rst);
            model_step(vecs[i].iv, vecs[i].ordy, vecs[i].rst, d_ir, d_load, d_ren, d_ov, d_oh);
            chk("vec_in_ready", 32'(s_ir), 32'(vecs[i].e_ir));
            chk("vec_load", 32'(s_load), 32'(vecs[i].e_load));
            chk("vec_round_en", 32'(s_ren), 32'(vecs[i].e_ren));
            chk("vec_out_valid", 32'(s_ov), 32'(vecs[i].e_ov));
            chk("vec_round_onehot", s_oh, vecs[i].e_oh);
        end

        // Single request, then back-pressure on the result.
        cycle(1, 0, 1);
        t0 = cyc;
        chk("single_load", 32'(s_load), 32'd1);
        ov_cyc  = -1;
        ren_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 1);
            if (s_ren) ren_cnt++;
            if (cyc == t0 + 1) chk("single_first_round", s_oh, 32'h000001);
            if (cyc == t0 + 24) chk("single_last_round", s_oh, 32'h800000);
            if (s_ov) begin
                ov_cyc = cyc;
                break;
            end
        end
        chk("single_out_valid_latency", 32'(ov_cyc - t0), 32'(NR + 1));
        chk("single_round_en_count", 32'(ren_cnt), 32'(NR));
        chk("single_onehot_cleared", s_oh, 32'h0);

        ov_cnt  = 1;
        ir_cnt  = s_ir ? 1 : 0;
        ren_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1);
            if (s_ov) ov_cnt++;
            if (s_ir) ir_cnt++;
            if (s_ren) ren_cnt++;
        end
        cycle(0, 1, 1);
        if (s_ov) ov_cnt++;
        if (s_ren) ren_cnt++;
        chk("bp_out_valid_cycles", 32'(ov_cnt), 32'd11);
        chk("bp_in_ready_while_stalled", 32'(ir_cnt), 32'd0);
        chk("bp_round_en_quiet", 32'(ren_cnt), 32'd0);
        cycle(0, 0, 1);
        chk("bp_back_to_idle_ov", 32'(s_ov), 32'd0);
        chk("bp_back_to_idle_ir", 32'(s_ir), 32'd1);

        // Reset while round 12 is executing.
        cycle(1, 0, 1);
        t0 = cyc;
        for (int i = 0; i < 11; i++) cycle(0, 0, 1);
        cycle(0, 0, 0);
        chk("rst_mid_round12", s_oh, 32'h000800);
        cycle(0, 1, 1);
        chk("rst_mid_onehot", s_oh, 32'h0);
        chk("rst_mid_in_ready", 32'(s_ir), 32'd1);
        chk("rst_mid_round_en", 32'(s_ren), 32'd0);
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 1);
            if (s_ov) ov_cnt++;
        end
        chk("rst_mid_no_out_valid", 32'(ov_cnt), 32'd0);

        // in_valid held throughout the run: a single acceptance, a single result.
        ld_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1, 0, 1);
            if (s_load) ld_cnt++;
        end
        hs_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1);
            if (s_ov) hs_cnt++;
        end
        chk("held_valid_loads", 32'(ld_cnt), 32'd1);
        chk("held_valid_results", 32'(hs_cnt), 32'd1);

        // Back-to-back: load-to-load distance NR+1 with overlap, NR+2 without
        // (26 / 27 cycles when both load cycles are counted).
        first_ld  = -1;
        second_ld = -1;
        for (int i = 0; i < 80; i++) begin
            cycle(1, 1, 1);
            if (s_load) begin
                if (first_ld < 0) first_ld = cyc;
                else if (second_ld < 0) second_ld = cyc;
            end
        end
        chk("b2b_period", 32'(second_ld - first_ld), OVL ? 32'(NR + 1) : 32'(NR + 2));
        cycle(0, 1, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 150) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 SHALL have parameter: NROUND, 24, rounds per permutation, equal to the one-hot round index width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  permutation request; the input state is presented by the parent.
REQ-005 SHALL have port: in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port: load  output  1  parent captures the input state into the permutation register this cycle.
REQ-007 SHALL have port: round_en  output  1  parent applies one round this cycle.
REQ-008 SHALL have port: round_onehot  output  NROUND  one-hot round index, fed directly to the round-constant generator.
REQ-009 SHALL have port: out_valid  output  1  permutation result available.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 IDLE SHALL drive in_ready=1, round_en=0, out_valid=0 and round_onehot=0.
REQ-013 IDLE with in_valid=1 SHALL assert load=1 (combinational) in that cycle and go to RUN with round_onehot set to bit 0 only.
REQ-014 RUN SHALL drive round_en=1, in_ready=0 and out_valid=0, and shift round_onehot left by one each cycle.
REQ-015 RUN with round_onehot[NROUND-1]=1 SHALL go to DONE next cycle and clear round_onehot to 0.
REQ-016 round_onehot SHALL have exactly one bit set in RUN and SHALL be all-zero in IDLE and DONE.
REQ-017 Latency SHALL be fixed: accept at cycle T, round_en high for cycles T+1..T+NROUND, out_valid high from cycle T+NROUND+1.
REQ-018 DONE SHALL hold out_valid=1 until out_ready=1, then go to IDLE.
REQ-019 Without the overlap feature, in_ready SHALL be 0 in DONE.
REQ-020 load SHALL only assert in a cycle where in_valid & in_ready = 1.
REQ-021 in_valid SHALL be ignored in RUN, with no effect on the sequence.
REQ-022 out_valid SHALL stay stable while out_ready=0; back-pressure SHALL be unlimited.

Reset
REQ-023 reset=0 at a clock edge SHALL force IDLE and round_onehot=0, so that after the edge round_en=0, out_valid=0, load=0 and in_ready=1.
REQ-024 Reset mid-RUN or mid-DONE SHALL abandon the permutation with no out_valid pulse.
REQ-025 While reset=0, load SHALL be forced to 0.

Configuration
REQ-026 The macro ROUND_CTRL_OVERLAP_EN SHALL select the DONE-state overlap feature.
REQ-027 With ROUND_CTRL_OVERLAP_EN defined, DONE SHALL drive in_ready=out_ready.
REQ-028 With ROUND_CTRL_OVERLAP_EN defined, DONE with out_ready=1 and in_valid=1 in the same cycle SHALL assert load and go directly to RUN with bit 0 set.
REQ-029 With ROUND_CTRL_OVERLAP_EN undefined, DONE SHALL always return to IDLE, giving one idle cycle between permutations.

Structure
REQ-030 Package sha3_pkg SHALL hold the NROUND default (24) and the FSM state enumeration.
REQ-031 There SHALL be no sub-module; the round-constant generator SHALL be instantiated by the parent and driven from round_onehot.

Verification
REQ-032 Single request: in_valid=1 for 1 cycle at T=0 -> load at T0, round_onehot=0x000001 at T1, 0x800000 at T24, round_en high 24 cycles, out_valid at T25, round_onehot=0 from T25.
REQ-033 Back-pressure: out_ready=0 for 10 cycles after out_valid rises -> out_valid held for 11 cycles, round_en stays 0, in_ready stays 0 (non-overlap build).
REQ-034 Reset mid-run: reset=0 at round 12 (round_onehot=0x000800) -> next cycle IDLE, round_onehot=0, in_ready=1, and no out_valid ever for that request.
REQ-035 in_valid held high during RUN -> no extra load, and exactly one out_valid per accepted request.
REQ-036 Overlap build: out_ready=1 and in_valid=1 in DONE -> load the same cycle, round_onehot=0x000001 next cycle, and back-to-back period of 26 cycles (27 without the macro).
REQ-037 Every cycle: assert $onehot0(round_onehot), and round_en == (round_onehot != 0).
